// File: rtl/seven_seg_mux.sv
// seven_seg_mux: N-digit multiplexed seven-segment driver with tear-free frames.
// Define SEVSEG_LZ_BLANK_EN to enable leading-zero suppression.
module seven_seg_mux #(
    parameter int NUM_DIGITS   = 4,
    parameter int DIGIT_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    output logic [6:0]              ss_abcdefg_l,
    output logic                    ss_dp_l,
    output logic [NUM_DIGITS-1:0]   ss_sel_l,
    output logic                    frame_sync
);

    localparam int CW = (DIGIT_CYCLES > 2) ? $clog2(DIGIT_CYCLES) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [CW-1:0]                cnt;
    logic [IW-1:0]                idx;
    logic [NUM_DIGITS-1:0][3:0]   sh_val;
    logic [NUM_DIGITS-1:0][3:0]   dsp_val;
    logic [NUM_DIGITS-1:0]        sh_dp;
    logic [NUM_DIGITS-1:0]        sh_en;
    logic [NUM_DIGITS-1:0]        dsp_dp;
    logic [NUM_DIGITS-1:0]        dsp_en;
    logic [NUM_DIGITS-1:0]        sup;
    logic                         slot_end;
    logic                         frame_start;
    logic                         blank;
    logic                         lit;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        unique case (n)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    assign slot_end    = (cnt == CW'(DIGIT_CYCLES - 1));
    assign frame_start = (cnt == '0) && (idx == '0);
    assign blank       = (32'(cnt) < 32'(BLANK_CYCLES));

`ifdef SEVSEG_LZ_BLANK_EN
    // A digit goes dark while it and everything above it is a bare zero.
    always_comb begin
        logic [NUM_DIGITS:0] zrun;
        zrun = '0;
        zrun[NUM_DIGITS] = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zrun[i] = zrun[i+1] & (dsp_val[i] == 4'h0) & ~dsp_dp[i];
        end
        sup = zrun[NUM_DIGITS-1:0] & ~NUM_DIGITS'(1);
    end
`else
    assign sup = '0;
`endif

    assign lit = ~blank & dsp_en[idx] & ~sup[idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            idx          <= '0;
            sh_val       <= '0;
            sh_dp        <= '0;
            sh_en        <= '0;
            dsp_val      <= '0;
            dsp_dp       <= '0;
            dsp_en       <= '0;
            ss_abcdefg_l <= 7'h7F;
            ss_dp_l      <= 1'b1;
            ss_sel_l     <= '1;
            frame_sync   <= 1'b0;
        end else begin
            cnt <= slot_end ? '0 : cnt + 1'b1;
            if (slot_end) begin
                idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
            end
            // Display regs take the shadow value seen before this edge's load.
            if (frame_start) begin
                dsp_val <= sh_val;
                dsp_dp  <= sh_dp;
                dsp_en  <= sh_en;
            end
            if (load) begin
                sh_val <= value;
                sh_dp  <= dp;
                sh_en  <= digit_en;
            end
            frame_sync   <= frame_start;
            ss_sel_l     <= lit ? ~(NUM_DIGITS'(1) << idx) : '1;
            ss_abcdefg_l <= lit ? hex7(dsp_val[idx]) : 7'h7F;
            ss_dp_l      <= ~(lit & dsp_dp[idx]);
        end
    end

endmodule
